seg7_frame_decoder: RTL and testbench
=====================================

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 Parameter NUM_DIGITS SHALL default to 4: number of multiplexed digit positions.
REQ-002 Parameter STABLE_CYCLES SHALL default to 8, legal range 1..255: consecutive identical samples required before a digit is captured.
REQ-003 There SHALL be one clock and asynchronous active-high reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 seg_n  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-006 dig_sel  input  NUM_DIGITS  one-hot digit strobe, bit i = digit i.
REQ-007 frame_bcd  output  4*NUM_DIGITS  decoded digits, digit i at bits [4i+3:4i].
REQ-008 frame_err  output  NUM_DIGITS  bit i set = digit i held an undecodable pattern.
REQ-009 frame_valid  output  1  one-cycle pulse: frame_bcd/frame_err updated.

Function
REQ-010 Decode table SHALL be exact: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-011 Any other pattern SHALL decode to value 4'h0 with error flag set.
REQ-012 A sample SHALL be the pair {seg_n, dig_sel}; a stability counter SHALL increment while the sample equals the previous cycle's sample and reload to 1 on any change.
REQ-013 A sample with dig_sel zero or not one-hot SHALL hold the counter at 0 and never capture.
REQ-014 When the counter reaches STABLE_CYCLES, the digit SHALL be captured on that edge into slot i and slot i marked filled; the counter SHALL saturate, capturing once per stable run.
REQ-015 A capture into an already-filled slot SHALL overwrite it (latest value wins).
REQ-016 Per-digit states SHALL be EMPTY -> FILLED; all slots FILLED SHALL drive frame transfer.
REQ-017 On the edge after all slots become filled, frame_bcd and frame_err SHALL load from the slots, frame_valid SHALL pulse high one cycle, and all fill marks SHALL clear.
REQ-018 A capture in the same cycle as frame transfer SHALL go to the new frame (its slot marked filled after clear).
REQ-019 frame_bcd and frame_err SHALL hold between frame_valid pulses.
REQ-020 Latency: sample first presented at cycle t, held steady -> captured at edge t+STABLE_CYCLES-1; frame_valid one cycle after the final digit's capture.

Reset
REQ-021 rst SHALL clear frame_bcd, frame_err, frame_valid, stability counter, previous-sample register, slot contents and fill marks to 0, asynchronously.
REQ-022 rst asserted mid-frame SHALL discard partial captures; no frame_valid follows deassertion until a full new set of digits is captured.

Configuration
REQ-023 Macro SEG7_HEX_DECODE_EN defined SHALL additionally decode 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F without error.
REQ-024 Macro SEG7_HEX_DECODE_EN undefined SHALL treat those six patterns as errors per REQ-011.

Structure
REQ-025 Package seg7_pkg SHALL hold the pattern constants (digits 0-9, A-F) and the decoded-digit width constant.
REQ-026 Combinational sub-module seg7_pattern_decode (seg_n in; value and error out) SHALL implement REQ-010/011/023/024.

Verification
REQ-027 Reset, then digits 1,2,3,4 on dig_sel 0001,0010,0100,1000, each held 8 cycles -> one frame_valid pulse, frame_bcd=16'h4321, frame_err=0.
REQ-028 Digit 0 held 7 cycles then changed -> no capture; held 8 cycles -> capture.
REQ-029 seg_n=7'b1111111 on digit 2 in a full frame -> frame_err=4'b0100, digit 2 field=0.
REQ-030 dig_sel=4'b0011 held 20 cycles -> no capture, no frame_valid.
REQ-031 rst pulsed after 3 of 4 digits captured, then only digit 3 captured -> no frame_valid; frame_bcd stays 0.
REQ-032 Pattern 7'b0001000 on all digits -> frame_bcd=16'hAAAA, frame_err=0 with SEG7_HEX_DECODE_EN; frame_bcd=0, frame_err=4'b1111 without.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment frame decoder:
//   - active-low segment patterns for hex digits 0-F (bit0=a .. bit6=g)
//   - width of one decoded digit
//   - per-digit slot state type
// No ports (package).
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int DIGIT_W = 4;

   // Decimal digit patterns, active low, {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   // Hex letter patterns, only decoded when SEG7_HEX_DECODE_EN is defined
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   typedef enum logic [0:0] {
      SLOT_EMPTY  = 1'b0,
      SLOT_FILLED = 1'b1
   } slot_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of one active-low seven-segment pattern to a digit.
// Unknown patterns give value 0 with error set.
// Build option: SEG7_HEX_DECODE_EN adds the letters A,b,C,d,E,F as valid
// digits; without it those patterns are reported as errors.
// Ports:
//   seg_n  in  [6:0]          active-low segments, bit0=a .. bit6=g
//   value  out [DIGIT_W-1:0]  decoded digit
//   error  out                pattern not recognised
// -----------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0]         seg_n,
   output logic [DIGIT_W-1:0] value,
   output logic               error
);

   // Pattern lookup
   always_comb begin
      value = 4'h0;
      error = 1'b0;
      case (seg_n)
         SEG_0:   value = 4'h0;
         SEG_1:   value = 4'h1;
         SEG_2:   value = 4'h2;
         SEG_3:   value = 4'h3;
         SEG_4:   value = 4'h4;
         SEG_5:   value = 4'h5;
         SEG_6:   value = 4'h6;
         SEG_7:   value = 4'h7;
         SEG_8:   value = 4'h8;
         SEG_9:   value = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
         SEG_A:   value = 4'hA;
         SEG_B:   value = 4'hB;
         SEG_C:   value = 4'hC;
         SEG_D:   value = 4'hD;
         SEG_E:   value = 4'hE;
         SEG_F:   value = 4'hF;
`endif
         default: begin
            value = 4'h0;
            error = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// -----------------------------------------------------------------------------
// seg7_frame_decoder
// Watches a multiplexed seven-segment display bus and rebuilds the displayed
// number. A digit is captured after its {seg_n, dig_sel} sample has been
// seen unchanged for STABLE_CYCLES consecutive cycles; once every digit
// position has been captured the whole frame is published with a one-cycle
// frame_valid pulse.
// Build option: SEG7_HEX_DECODE_EN (in seg7_pattern_decode) enables A-F.
// Ports:
//   clk          in                 rising-edge clock
//   rst          in                 asynchronous active-high reset
//   seg_n        in  [6:0]          active-low segments, bit0=a .. bit6=g
//   dig_sel      in  [NUM_DIGITS-1:0]   one-hot digit strobe
//   frame_bcd    out [4*NUM_DIGITS-1:0] digit i at [4i+3:4i]
//   frame_err    out [NUM_DIGITS-1:0]   digit i was undecodable
//   frame_valid  out                one-cycle pulse on frame update
// -----------------------------------------------------------------------------
module seg7_frame_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [6:0]                  seg_n,
   input  logic [NUM_DIGITS-1:0]       dig_sel,
   output logic [DIGIT_W*NUM_DIGITS-1:0] frame_bcd,
   output logic [NUM_DIGITS-1:0]       frame_err,
   output logic                        frame_valid
);

   localparam int         SAMPLE_W = 7 + NUM_DIGITS;
   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   logic [SAMPLE_W-1:0]           sample_s;
   logic [SAMPLE_W-1:0]           prev_sample_r;
   logic [7:0]                    cnt_r;
   logic [7:0]                    cnt_next_s;
   logic                          onehot_s;
   logic                          capture_s;
   logic                          all_filled_s;
   logic [DIGIT_W-1:0]            dec_value_s;
   logic                          dec_err_s;
   slot_state_t                   slot_state_r [NUM_DIGITS];
   logic [DIGIT_W*NUM_DIGITS-1:0] slot_bcd_r;
   logic [NUM_DIGITS-1:0]         slot_err_r;

   assign sample_s = {seg_n, dig_sel};
   assign onehot_s = $onehot(dig_sel);

   seg7_pattern_decode u_decode (
      .seg_n (seg_n),
      .value (dec_value_s),
      .error (dec_err_s)
   );

   // Stability counter next value and capture strobe. The capture fires only
   // on the edge where the count arrives at STABLE_CYCLES, so a saturated run
   // captures once; a fresh run reloads to 1, which is itself a capture when
   // STABLE_CYCLES is 1.
   always_comb begin
      cnt_next_s = cnt_r;
      capture_s  = 1'b0;
      if (!onehot_s) begin
         cnt_next_s = 8'd0;
         capture_s  = 1'b0;
      end else if (sample_s != prev_sample_r) begin
         cnt_next_s = 8'd1;
         capture_s  = (STABLE_C == 8'd1);
      end else if (cnt_r < STABLE_C) begin
         cnt_next_s = cnt_r + 8'd1;
         capture_s  = ((cnt_r + 8'd1) == STABLE_C);
      end else begin
         cnt_next_s = cnt_r;
         capture_s  = 1'b0;
      end
   end

   // Frame is complete when every slot holds a capture
   always_comb begin
      all_filled_s = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         all_filled_s = all_filled_s & (slot_state_r[i] == SLOT_FILLED);
      end
   end

   // Sample history, slot capture, per-slot EMPTY/FILLED state and frame
   // transfer. A capture on the transfer edge wins over the clear so it
   // belongs to the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_sample_r <= '0;
         cnt_r         <= 8'd0;
         slot_bcd_r    <= '0;
         slot_err_r    <= '0;
         frame_bcd     <= '0;
         frame_err     <= '0;
         frame_valid   <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            slot_state_r[i] <= SLOT_EMPTY;
         end
      end else begin
         prev_sample_r <= sample_s;
         cnt_r         <= cnt_next_s;
         frame_valid   <= all_filled_s;
         if (all_filled_s) begin
            frame_bcd <= slot_bcd_r;
            frame_err <= slot_err_r;
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture_s && dig_sel[i]) begin
               slot_bcd_r[DIGIT_W*i +: DIGIT_W] <= dec_value_s;
               slot_err_r[i]                    <= dec_err_s;
               slot_state_r[i]                  <= SLOT_FILLED;
            end else if (all_filled_s) begin
               slot_state_r[i] <= SLOT_EMPTY;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
module tb_seg7_frame_decoder;

   localparam int ND     = 4;
   localparam int STABLE = 8;
`ifdef SEG7_HEX_DECODE_EN
   localparam int NUM_DEC = 16;
   localparam bit HEX_EN  = 1'b1;
`else
   localparam int NUM_DEC = 10;
   localparam bit HEX_EN  = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [6:0]    seg_n;
   logic [ND-1:0] dig_sel;
   logic [15:0]   frame_bcd;
   logic [3:0]    frame_err;
   logic          frame_valid;

   seg7_frame_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .dig_sel     (dig_sel),
      .frame_bcd   (frame_bcd),
      .frame_err   (frame_err),
      .frame_valid (frame_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int vcount = 0;

   // Reference pattern table, index = digit value
   logic [6:0] pat_tab [16];

   // Behavioural model state
   logic [10:0] m_last;
   int          m_run;
   logic [3:0]  m_val [4];
   logic        m_e   [4];
   logic [3:0]  m_filled;
   logic [15:0] m_bcd;
   logic [3:0]  m_err;
   logic        m_valid;

   typedef struct {
      logic [6:0]  seg;
      logic [15:0] exp_bcd;
      logic [3:0]  exp_err;
   } vec_t;
   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_decode(input logic [6:0] s, output logic [3:0] v, output logic e);
      v = 4'h0;
      e = 1'b1;
      for (int k = 0; k < NUM_DEC; k++) begin
         if (pat_tab[k] == s) begin
            v = 4'(k);
            e = 1'b0;
         end
      end
   endfunction

   task automatic model_reset();
      m_last   = '0;
      m_run    = 0;
      m_filled = '0;
      m_bcd    = '0;
      m_err    = '0;
      m_valid  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_val[k] = 4'h0;
         m_e[k]   = 1'b0;
      end
   endtask

   // One clock edge of the specified behaviour, applied to the inputs held
   // during the preceding cycle.
   task automatic model_edge(input logic [6:0] s, input logic [3:0] d);
      logic [3:0] v;
      logic       e;
      if ($countones(d) != 1) m_run = 0;
      else if ({s, d} != m_last) m_run = 1;
      else m_run = m_run + 1;
      m_last = {s, d};
      if (m_filled == 4'hF) begin
         for (int k = 0; k < 4; k++) begin
            m_bcd[4*k +: 4] = m_val[k];
            m_err[k]        = m_e[k];
         end
         m_valid  = 1'b1;
         m_filled = 4'h0;
      end else begin
         m_valid = 1'b0;
      end
      if (m_run == STABLE) begin
         ref_decode(s, v, e);
         for (int k = 0; k < 4; k++) begin
            if (d[k]) begin
               m_val[k]    = v;
               m_e[k]      = e;
               m_filled[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input logic [6:0] s, input logic [3:0] d);
      seg_n   = s;
      dig_sel = d;
      @(posedge clk);
      model_edge(s, d);
      #1;
      if (frame_valid === 1'b1) vcount++;
      check("cyc_valid", 32'(frame_valid), 32'(m_valid));
      check("cyc_bcd",   32'(frame_bcd),   32'(m_bcd));
      check("cyc_err",   32'(frame_err),   32'(m_err));
   endtask

   task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
      for (int c = 0; c < n; c++) step(s, d);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      seg_n   = 7'b1111111;
      dig_sel = 4'h0;
      #1;
      model_reset();
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_bcd",   32'(frame_bcd),   32'd0);
      check("rst_err",   32'(frame_err),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Capture one digit pattern into each of the four positions, then idle
   task automatic full_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      hold(s0, 4'b0001, STABLE);
      hold(s1, 4'b0010, STABLE);
      hold(s2, 4'b0100, STABLE);
      hold(s3, 4'b1000, STABLE);
      hold(7'b1111111, 4'b0000, 2);
   endtask

   initial begin
      int          v0;
      logic [31:0] rv;
      logic [3:0]  d;
      logic [6:0]  s;

      pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001;
      pat_tab[2]  = 7'b0100100; pat_tab[3]  = 7'b0110000;
      pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
      pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000;
      pat_tab[8]  = 7'b0000000; pat_tab[9]  = 7'b0010000;
      pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
      pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001;
      pat_tab[14] = 7'b0000110; pat_tab[15] = 7'b0001110;

      // Whole-frame vectors: same pattern in all four positions
      vecs[0]  = '{7'b1000000, 16'h0000, 4'b0000};
      vecs[1]  = '{7'b1111001, 16'h1111, 4'b0000};
      vecs[2]  = '{7'b0100100, 16'h2222, 4'b0000};
      vecs[3]  = '{7'b0110000, 16'h3333, 4'b0000};
      vecs[4]  = '{7'b0011001, 16'h4444, 4'b0000};
      vecs[5]  = '{7'b0010010, 16'h5555, 4'b0000};
      vecs[6]  = '{7'b0000010, 16'h6666, 4'b0000};
      vecs[7]  = '{7'b1111000, 16'h7777, 4'b0000};
      vecs[8]  = '{7'b0000000, 16'h8888, 4'b0000};
      vecs[9]  = '{7'b0010000, 16'h9999, 4'b0000};
      vecs[10] = '{7'b1111111, 16'h0000, 4'b1111};
      vecs[11] = '{7'b1111110, 16'h0000, 4'b1111};
      if (HEX_EN) vecs[12] = '{7'b0001000, 16'hAAAA, 4'b0000};
      else        vecs[12] = '{7'b0001000, 16'h0000, 4'b1111};

      rst     = 1'b0;
      seg_n   = 7'b1111111;
      dig_sel = 4'h0;
      model_reset();
      #2;
      do_reset();

      // Basic frame 4321
      vcount = 0;
      full_frame(pat_tab[1], pat_tab[2], pat_tab[3], pat_tab[4]);
      check("f4321_pulses", 32'(vcount), 32'd1);
      check("f4321_bcd", 32'(frame_bcd), 32'h4321);
      check("f4321_err", 32'(frame_err), 32'h0);

      // Table-driven frames
      for (int i = 0; i < 13; i++) begin
         v0 = vcount;
         full_frame(vecs[i].seg, vecs[i].seg, vecs[i].seg, vecs[i].seg);
         check("vec_pulses", 32'(vcount - v0), 32'd1);
         check("vec_bcd", 32'(frame_bcd), 32'(vecs[i].exp_bcd));
         check("vec_err", 32'(frame_err), 32'(vecs[i].exp_err));
      end

      // 7 stable cycles do not capture, 8 do
      do_reset();
      vcount = 0;
      hold(pat_tab[0], 4'b0001, STABLE - 1);
      hold(7'b1111111, 4'b0000, 1);
      hold(pat_tab[5], 4'b0010, STABLE);
      hold(pat_tab[6], 4'b0100, STABLE);
      hold(pat_tab[7], 4'b1000, STABLE);
      hold(7'b1111111, 4'b0000, 3);
      check("short_hold_no_frame", 32'(vcount), 32'd0);
      hold(pat_tab[0], 4'b0001, STABLE);
      hold(7'b1111111, 4'b0000, 2);
      check("long_hold_frame", 32'(vcount), 32'd1);
      check("long_hold_bcd", 32'(frame_bcd), 32'h7650);

      // Blank pattern on digit 2
      vcount = 0;
      full_frame(pat_tab[9], pat_tab[8], 7'b1111111, pat_tab[3]);
      check("blank_pulses", 32'(vcount), 32'd1);
      check("blank_bcd", 32'(frame_bcd), 32'h3089);
      check("blank_err", 32'(frame_err), 32'b0100);

      // Non-one-hot strobe never captures; other slots alone cannot finish
      do_reset();
      vcount = 0;
      hold(pat_tab[1], 4'b0011, 20);
      hold(pat_tab[2], 4'b0100, STABLE);
      hold(pat_tab[3], 4'b1000, STABLE);
      hold(7'b1111111, 4'b0000, 3);
      check("multi_hot_no_frame", 32'(vcount), 32'd0);
      check("multi_hot_bcd", 32'(frame_bcd), 32'h0);

      // Reset mid-frame discards partial captures
      do_reset();
      vcount = 0;
      hold(pat_tab[1], 4'b0001, STABLE);
      hold(pat_tab[2], 4'b0010, STABLE);
      hold(pat_tab[3], 4'b0100, STABLE);
      do_reset();
      hold(pat_tab[4], 4'b1000, STABLE);
      hold(7'b1111111, 4'b0000, 4);
      check("midrst_no_frame", 32'(vcount), 32'd0);
      check("midrst_bcd", 32'(frame_bcd), 32'h0);

      // Randomised traffic against the model
      for (int it = 0; it < 300; it++) begin
         rv = $urandom;
         if (rv[4:0] == 5'd0) do_reset();
         if (rv[7:5] == 3'd0) d = rv[11:8];
         else d = 4'(1 << rv[13:12]);
         if (rv[17:15] == 3'd0) s = rv[24:18];
         else s = pat_tab[rv[28:25]];
         hold(s, d, $urandom_range(5, 11));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
